prbs_gen_chk: RTL and testbench

PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

---
 rtl/prbs_gen_chk.sv | 203 ++++++++++++++++++++
 tb/tb_prbs_gen_chk.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_gen_chk.sv
// PRBS7/9/15/31 generator plus self-synchronising checker with lock, loss and error counting.
// Latency 1 cycle on o_data/o_valid and o_err/o_err_cnt; no backpressure, words qualified by i_enable/i_rx_valid.
module prbs_gen_chk #(
  parameter int          DW       = 1,
  parameter logic [30:0] SEED     = 31'h000001AA,
  parameter int          LOCK_CNT = 32,
  parameter int          LOSS_CNT = 4,
  parameter int          CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [1:0]       i_mode,
  input  logic             i_clr_err,
  input  logic [DW-1:0]    i_rx_data,
  input  logic             i_rx_valid,
  output logic [DW-1:0]    o_data,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int EW = $clog2(DW + 1);
  localparam int SW = ((CNT_W > EW) ? CNT_W : EW) + 1;
  localparam logic [SW-1:0] CNT_MAX = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  function automatic logic [30:0] poly_mask(input logic [1:0] m);
    case (m)
      2'd0:    return 31'h0000_007F;
      2'd1:    return 31'h0000_01FF;
      2'd2:    return 31'h0000_7FFF;
      default: return 31'h7FFF_FFFF;
    endcase
  endfunction

  // Index of the top state bit (N-1)
  function automatic logic [4:0] poly_top(input logic [1:0] m);
    case (m)
      2'd0:    return 5'd6;
      2'd1:    return 5'd8;
      2'd2:    return 5'd14;
      default: return 5'd30;
    endcase
  endfunction

  function automatic logic [4:0] poly_tap(input logic [1:0] m);
    case (m)
      2'd0:    return 5'd1;
      2'd1:    return 5'd4;
      2'd2:    return 5'd1;
      default: return 5'd3;
    endcase
  endfunction

  function automatic logic [30:0] seed_for(input logic [1:0] m);
    logic [30:0] s;
    s = SEED & poly_mask(m);
    return (s == '0) ? 31'd1 : s;
  endfunction

  // Bits above N-1 are zero, so the right shift leaves bit N-1 free for the new bit
  function automatic logic [30:0] shift_in(input logic [30:0] r, input logic b, input logic [4:0] top);
    logic [30:0] v;
    v      = r >> 1;
    v[top] = b;
    return v;
  endfunction

  logic [1:0]       mode_q;
  logic             mode_chg;
  logic [4:0]       top, tap;
  logic [30:0]      g_q, g_d;
  logic [DW-1:0]    data_d;
  state_t           state_q, state_d;
  logic [30:0]      c_q, c_d;
  logic [4:0]       fill_q, fill_d;
  logic [31:0]      good_q, good_d;
  logic [31:0]      bad_q, bad_d;
  logic [EW-1:0]    nerr;
  logic             err_d;
  logic [SW-1:0]    sum;
  logic [CNT_W-1:0] cnt_d;
  logic             rx_bit, pred;

  assign mode_chg = (i_mode != mode_q);
  assign top      = poly_top(mode_q);
  assign tap      = poly_tap(mode_q);
  assign o_locked = (state_q == LOCKED);

  always_comb begin
    g_d    = ((g_q & poly_mask(mode_q)) == '0) ? seed_for(mode_q) : g_q;
    data_d = o_data;
    for (int k = 0; k < DW; k++) begin
      data_d[k] = g_d[0];
      g_d       = shift_in(g_d, g_d[0] ^ g_d[tap], top);
    end
  end

  always_comb begin
    c_d     = c_q;
    fill_d  = fill_q;
    good_d  = good_q;
    bad_d   = bad_q;
    state_d = state_q;
    nerr    = '0;
    err_d   = 1'b0;
    rx_bit  = 1'b0;
    pred    = 1'b0;
    if (i_rx_valid) begin
      for (int k = 0; k < DW; k++) begin
        rx_bit = i_rx_data[k];
        pred   = c_d[0] ^ c_d[tap];
        if (state_q == LOCKED) begin
          if (rx_bit != pred) nerr = nerr + EW'(1);
          c_d = shift_in(c_d, pred, top);
        end else begin
          if (fill_d <= top)       fill_d = fill_d + 5'd1;
          else if (rx_bit == pred) good_d = good_d + 32'd1;
          else                     good_d = '0;
          c_d = shift_in(c_d, rx_bit, top);
        end
      end
      if (state_q == HUNT) begin
        if (good_d >= 32'(LOCK_CNT)) begin
          state_d = LOCKED;
          bad_d   = '0;
        end
      end else if (nerr != '0) begin
        err_d = 1'b1;
        bad_d = bad_q + 32'd1;
        if (bad_d >= 32'(LOSS_CNT)) begin
          state_d = HUNT;
          fill_d  = '0;
          good_d  = '0;
          bad_d   = '0;
        end
      end else begin
        bad_d = '0;
      end
    end
    // A polynomial switch wins over any lock/loss decision made above
    if (mode_chg) begin
      state_d = HUNT;
      c_d     = '0;
      fill_d  = '0;
      good_d  = '0;
      bad_d   = '0;
      err_d   = 1'b0;
      nerr    = '0;
    end
  end

  always_comb begin
    sum   = (i_clr_err ? '0 : SW'(o_err_cnt)) + (err_d ? SW'(nerr) : '0);
    cnt_d = o_err_cnt;
    if (i_clr_err || err_d) cnt_d = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mode_q  <= 2'd1;
      g_q     <= seed_for(2'd1);
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      mode_q <= i_mode;
      if (mode_chg) begin
        g_q     <= seed_for(i_mode);
        o_valid <= 1'b0;
      end else if (i_enable) begin
        g_q     <= g_d;
        o_data  <= data_d;
        o_valid <= 1'b1;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= HUNT;
      c_q       <= '0;
      fill_q    <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      fill_q    <= fill_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      o_err     <= err_d;
      o_err_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Bench for prbs_gen_chk: a DW=1 instance (PRBS9 sequence, loss/relock) and a DW=8, CNT_W=4 instance
// (PRBS31 loopback, bit errors, mode change, saturation) fed back through an error-injection XOR.
module tb_prbs_gen_chk;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       en8, clr8, v8, lk8, err8;
  logic [1:0] mode8;
  logic [7:0] d8, flip8, rx8;
  logic [3:0] cnt8;
  assign rx8 = d8 ^ flip8;

  prbs_gen_chk #(.DW(8), .CNT_W(4)) u_dut8 (
    .i_clk(clk), .i_reset(rst), .i_enable(en8), .i_mode(mode8), .i_clr_err(clr8),
    .i_rx_data(rx8), .i_rx_valid(v8), .o_data(d8), .o_valid(v8), .o_locked(lk8),
    .o_err(err8), .o_err_cnt(cnt8));

  logic        en1, clr1, v1, lk1, err1, d1, flip1, rx1;
  logic [1:0]  mode1;
  logic [15:0] cnt1;
  assign rx1 = d1 ^ flip1;

  prbs_gen_chk #(.DW(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_enable(en1), .i_mode(mode1), .i_clr_err(clr1),
    .i_rx_data(rx1), .i_rx_valid(v1), .o_data(d1), .o_valid(v1), .o_locked(lk1),
    .o_err(err1), .o_err_cnt(cnt1));

  logic [30:0] m8, m1;
  int          n8;
  logic [4:0]  t8;
  logic [7:0]  qg8[$];
  int          qe8[$];
  logic        qg1[$];
  int          qe1[$];
  int          ec8 = 0;
  int          ec1 = 0;

  function automatic logic [30:0] lfsr(input logic [30:0] r, input int n, input logic [4:0] t);
    logic f;
    f = r[0] ^ r[t];
    return (r >> 1) | ({30'd0, f} << (n - 1));
  endfunction

  // One cycle on the DW=8 instance; flip corrupts the word currently on o_data as the checker takes it
  task automatic tick8(input logic en, input logic [7:0] flip, input logic lk, input logic clr);
    logic [7:0] w;
    logic       consumed;
    int         e;
    consumed = v8;
    if (consumed) qe8.push_back(lk ? $countones(flip) : 0);
    en8 = en; flip8 = flip; clr8 = clr;
    if (en) begin
      w = '0;
      for (int k = 0; k < 8; k++) begin
        w[k] = m8[0];
        m8   = lfsr(m8, n8, t8);
      end
      qg8.push_back(w);
    end
    @(posedge clk); #1;
    checks++;
    if (en) begin
      w = qg8.pop_front();
      if (v8 !== 1'b1 || d8 !== w) begin
        errors++;
        $display("FAIL gen8: valid=%b data=%h, expected valid=1 data=%h", v8, d8, w);
      end
    end else if (v8 !== 1'b0) begin
      errors++;
      $display("FAIL gen8_idle: valid=%b, expected 0", v8);
    end
    e = consumed ? qe8.pop_front() : 0;
    if (clr) ec8 = 0;
    ec8 = ec8 + e;
    if (ec8 > 15) ec8 = 15;
    checks++;
    if (err8 !== (e != 0) || cnt8 !== 4'(ec8)) begin
      errors++;
      $display("FAIL chk8: err=%b cnt=%0d, expected err=%b cnt=%0d", err8, cnt8, (e != 0), ec8);
    end
  endtask

  task automatic tick1(input logic en, input logic flip, input logic lk);
    logic w, consumed;
    int   e;
    consumed = v1;
    if (consumed) qe1.push_back((lk && flip) ? 1 : 0);
    en1 = en; flip1 = flip;
    if (en) begin
      qg1.push_back(m1[0]);
      m1 = lfsr(m1, 9, 5'd4);
    end
    @(posedge clk); #1;
    checks++;
    if (en) begin
      w = qg1.pop_front();
      if (v1 !== 1'b1 || d1 !== w) begin
        errors++;
        $display("FAIL gen1: valid=%b data=%b, expected valid=1 data=%b", v1, d1, w);
      end
    end else if (v1 !== 1'b0) begin
      errors++;
      $display("FAIL gen1_idle: valid=%b, expected 0", v1);
    end
    e = consumed ? qe1.pop_front() : 0;
    ec1 = ec1 + e;
    checks++;
    if (err1 !== (e != 0) || cnt1 !== 16'(ec1)) begin
      errors++;
      $display("FAIL chk1: err=%b cnt=%0d, expected err=%b cnt=%0d", err1, cnt1, (e != 0), ec1);
    end
  endtask

  task automatic wait_lock8(input int limit, input string name);
    int i;
    i = 0;
    while (lk8 !== 1'b1 && i < limit) begin
      tick8(1'b1, 8'h00, 1'b0, 1'b0);
      i++;
    end
    checks++;
    if (lk8 !== 1'b1) begin
      errors++;
      $display("FAIL %s: o_locked=%b after %0d words, expected 1", name, lk8, i);
    end
  endtask

  task automatic wait_lock1(input int limit, input string name);
    int i;
    i = 0;
    while (lk1 !== 1'b1 && i < limit) begin
      tick1(1'b1, 1'b0, 1'b0);
      i++;
    end
    checks++;
    if (lk1 !== 1'b1) begin
      errors++;
      $display("FAIL %s: o_locked=%b after %0d words, expected 1", name, lk1, i);
    end
  endtask

  task automatic set_mode8(input logic [1:0] m, input logic [30:0] seed, input int n, input logic [4:0] t);
    mode8 = m;
    tick8(1'b0, 8'h00, 1'b0, 1'b0);
    m8 = seed; n8 = n; t8 = t;
    checks++;
    if (lk8 !== 1'b0) begin
      errors++;
      $display("FAIL mode_change_unlock: o_locked=%b, expected 0", lk8);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en8 = 1'b0; clr8 = 1'b0; flip8 = '0; mode8 = 2'd1;
    en1 = 1'b0; clr1 = 1'b0; flip1 = 1'b0; mode1 = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (d8 !== 8'h00 || v8 !== 1'b0 || lk8 !== 1'b0 || err8 !== 1'b0 || cnt8 !== 4'd0) begin
      errors++;
      $display("FAIL reset8: data=%h valid=%b locked=%b err=%b cnt=%0d, expected all 0", d8, v8, lk8, err8, cnt8);
    end
    checks++;
    if (d1 !== 1'b0 || v1 !== 1'b0 || lk1 !== 1'b0 || err1 !== 1'b0 || cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL reset1: data=%b valid=%b locked=%b err=%b cnt=%0d, expected all 0", d1, v1, lk1, err1, cnt1);
    end
    rst = 1'b0;
    m1 = 31'h1AA;
  endtask

  task automatic test_prbs9_sequence();
    logic       seq[540];
    logic [8:0] first9;
    first9 = 9'b1_1010_1010;
    for (int i = 0; i < 540; i++) begin
      tick1(1'b1, 1'b0, 1'b0);
      seq[i] = d1;
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (seq[i] !== first9[i]) begin
        errors++;
        $display("FAIL prbs9_bit%0d: got %b, expected %b", i, seq[i], first9[i]);
      end
    end
    for (int i = 0; i < 29; i++) begin
      checks++;
      if (seq[i + 511] !== seq[i]) begin
        errors++;
        $display("FAIL prbs9_period bit %0d: got %b, expected %b", i + 511, seq[i + 511], seq[i]);
      end
    end
    checks++;
    if (lk1 !== 1'b1) begin
      errors++;
      $display("FAIL prbs9_lock: o_locked=%b, expected 1", lk1);
    end
  endtask

  task automatic test_loss_relock();
    for (int j = 0; j < 4; j++) begin
      tick1(1'b1, 1'b1, 1'b1);
      checks++;
      if (lk1 !== (j < 3)) begin
        errors++;
        $display("FAIL loss_word%0d: o_locked=%b, expected %b", j, lk1, (j < 3));
      end
    end
    wait_lock1(60, "relock1");
    checks++;
    if (cnt1 !== 16'd4) begin
      errors++;
      $display("FAIL relock_cnt: o_err_cnt=%0d, expected 4", cnt1);
    end
    tick1(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_loopback31();
    set_mode8(2'd3, 31'h1AA, 31, 5'd3);
    wait_lock8(11, "lock_prbs31");
    repeat (10000) tick8(1'b1, 8'h00, 1'b1, 1'b0);
    checks++;
    if (cnt8 !== 4'd0) begin
      errors++;
      $display("FAIL loopback31_cnt: o_err_cnt=%0d, expected 0", cnt8);
    end
  endtask

  task automatic test_bit_errors();
    tick8(1'b1, 8'h10, 1'b1, 1'b0);
    checks++;
    if (lk8 !== 1'b1 || cnt8 !== 4'd1) begin
      errors++;
      $display("FAIL single_flip: locked=%b cnt=%0d, expected locked=1 cnt=1", lk8, cnt8);
    end
    repeat (3) tick8(1'b1, 8'h00, 1'b1, 1'b0);
    tick8(1'b1, 8'h43, 1'b1, 1'b0);
    repeat (2) tick8(1'b1, 8'h00, 1'b1, 1'b0);
    checks++;
    if (lk8 !== 1'b1 || cnt8 !== 4'd4) begin
      errors++;
      $display("FAIL triple_flip: locked=%b cnt=%0d, expected locked=1 cnt=4", lk8, cnt8);
    end
  endtask

  task automatic test_mode_change();
    set_mode8(2'd1, 31'h1AA, 9, 5'd4);
    wait_lock8(15, "lock_prbs9");
    set_mode8(2'd0, 31'h2A, 7, 5'd1);
    wait_lock8(12, "lock_prbs7");
  endtask

  task automatic test_saturation();
    logic [7:0] fm;
    tick8(1'b1, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      fm = 8'h01 << (i % 8);
      tick8(1'b1, fm, 1'b1, 1'b0);
      tick8(1'b1, 8'h00, 1'b1, 1'b0);
    end
    checks++;
    if (cnt8 !== 4'd15) begin
      errors++;
      $display("FAIL saturate: o_err_cnt=%0d, expected 15", cnt8);
    end
    tick8(1'b1, 8'h07, 1'b1, 1'b1);
    checks++;
    if (cnt8 !== 4'd3 || lk8 !== 1'b1) begin
      errors++;
      $display("FAIL clr_with_err: cnt=%0d locked=%b, expected cnt=3 locked=1", cnt8, lk8);
    end
    tick8(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    checks++;
    if (lk1 !== 1'b1 || lk8 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_lock: locked1=%b locked8=%b, expected 1 1", lk1, lk8);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (lk1 !== 1'b0 || lk8 !== 1'b0 || cnt8 !== 4'd0 || cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: locked1=%b locked8=%b cnt1=%0d cnt8=%0d, expected all 0", lk1, lk8, cnt1, cnt8);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    m8 = 31'h1AA; n8 = 9; t8 = 5'd4;
    test_reset();
    test_prbs9_sequence();
    test_loss_relock();
    test_loopback31();
    test_bit_errors();
    test_mode_change();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
